// File: rtl/dac_sample_scheduler.sv
// ---------------------------------------------------------------------------
// dac_sample_scheduler
//
// Shares one stereo DAC between NUM_VOICES sample producers. A free-running
// period counter produces the sample-rate tick. After each tick the
// scheduler grants every voice in turn for one cycle, sums the samples it
// accepts, and then commits the mixed pair to held DAC output registers.
//
// Optional feature (compile-time macro DAC_SCHED_AVERAGE_EN):
//   undefined : saturating-sum mix (default)
//   defined   : averaging mix, acc >> $clog2(NUM_VOICES), truncating;
//               NUM_VOICES must then be a power of 2.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   voice_valid  in   [NUM_VOICES]        voice i has a sample pair ready
//   voice_left   in   [NUM_VOICES*WIDTH]  voice i left  = [i*WIDTH +: WIDTH]
//   voice_right  in   [NUM_VOICES*WIDTH]  voice i right = [i*WIDTH +: WIDTH]
//   voice_ready  out  [NUM_VOICES]        one-hot grant during voice i's slot
//   clear_status in   clears the missed sticky bits
//   left_out     out  [WIDTH]             mixed left sample, held between commits
//   right_out    out  [WIDTH]             mixed right sample, held between commits
//   sample_tick  out  one-cycle pulse on the last count of each period
//   out_strobe   out  one-cycle pulse aligned with new left_out/right_out
//   missed       out  [NUM_VOICES]        sticky: voice i was not valid in its slot
// ---------------------------------------------------------------------------
module dac_sample_scheduler #(
  parameter int WIDTH       = 4,
  parameter int SAMPLE_TIME = 656,
  parameter int NUM_VOICES  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_VOICES-1:0]         voice_valid,
  input  logic [NUM_VOICES*WIDTH-1:0]   voice_left,
  input  logic [NUM_VOICES*WIDTH-1:0]   voice_right,
  output logic [NUM_VOICES-1:0]         voice_ready,
  input  logic                          clear_status,
  output logic [WIDTH-1:0]              left_out,
  output logic [WIDTH-1:0]              right_out,
  output logic                          sample_tick,
  output logic                          out_strobe,
  output logic [NUM_VOICES-1:0]         missed
);

  // Accumulator is wide enough that summing every voice at full scale
  // cannot overflow.
  localparam int AW = WIDTH + $clog2(NUM_VOICES);
  localparam int CW = (SAMPLE_TIME > 1) ? $clog2(SAMPLE_TIME) : 1;
  localparam int SW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [CW-1:0]         count;
  logic [1:0]            state;
  logic [SW-1:0]         slot;
  logic [AW-1:0]         acc_l;
  logic [AW-1:0]         acc_r;
  logic [WIDTH-1:0]      cur_l;
  logic [WIDTH-1:0]      cur_r;
  logic                  cur_valid;
  logic [NUM_VOICES-1:0] miss_set;
  logic [WIDTH-1:0]      mix_l;
  logic [WIDTH-1:0]      mix_r;

  assign sample_tick = (count == CW'(SAMPLE_TIME - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (sample_tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Pick out the voice that owns the current slot. The grant is only
  // raised while collecting, so a voice holding valid outside its own
  // slot is never accepted.
  always_comb begin
    cur_l       = '0;
    cur_r       = '0;
    cur_valid   = 1'b0;
    voice_ready = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (slot == SW'(i)) begin
        cur_l     = voice_left[i*WIDTH +: WIDTH];
        cur_r     = voice_right[i*WIDTH +: WIDTH];
        cur_valid = voice_valid[i];
        if (state == COLLECT) begin
          voice_ready[i] = 1'b1;
        end
      end
    end
  end

  // The grant is one-hot on the current slot, so it doubles as the mask
  // of the missed bit to set when that voice had nothing to offer.
  assign miss_set = (state == COLLECT && !cur_valid) ? voice_ready : '0;

`ifdef DAC_SCHED_AVERAGE_EN
  generate
    if ((NUM_VOICES & (NUM_VOICES - 1)) != 0) begin : g_pow2_check
      $error("dac_sample_scheduler: NUM_VOICES must be a power of 2 for averaging mix");
    end
  endgenerate

  assign mix_l = WIDTH'(acc_l >> $clog2(NUM_VOICES));
  assign mix_r = WIDTH'(acc_r >> $clog2(NUM_VOICES));
`else
  localparam logic [AW-1:0] MAX_SAMPLE = AW'((1 << WIDTH) - 1);

  assign mix_l = (acc_l > MAX_SAMPLE) ? {WIDTH{1'b1}} : acc_l[WIDTH-1:0];
  assign mix_r = (acc_r > MAX_SAMPLE) ? {WIDTH{1'b1}} : acc_r[WIDTH-1:0];
`endif

  // Sticky missed bits: a new miss wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      slot       <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      left_out   <= '0;
      right_out  <= '0;
      out_strobe <= 1'b0;
      missed     <= '0;
    end else begin
      out_strobe <= 1'b0;
      missed     <= (missed & ~{NUM_VOICES{clear_status}}) | miss_set;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= COLLECT;
            slot  <= '0;
            acc_l <= '0;
            acc_r <= '0;
          end
        end
        COLLECT: begin
          if (cur_valid) begin
            acc_l <= acc_l + AW'(cur_l);
            acc_r <= acc_r + AW'(cur_r);
          end
          if (slot == SW'(NUM_VOICES - 1)) begin
            state <= COMMIT;
          end else begin
            slot <= slot + SW'(1);
          end
        end
        COMMIT: begin
          left_out   <= mix_l;
          right_out  <= mix_r;
          out_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_scheduler
//
// Scoreboard bench for dac_sample_scheduler (WIDTH=4, NUM_VOICES=4,
// SAMPLE_TIME=16). The stimulus process loads each sample period's voice
// data right after the tick and queues the expected grants and committed
// mix; a separate monitor pops and compares whenever the DUT grants a
// voice or strobes a new output pair.
// ---------------------------------------------------------------------------
module tb_dac_sample_scheduler;

  localparam int WIDTH       = 4;
  localparam int NUM_VOICES  = 4;
  localparam int SAMPLE_TIME = 16;

  typedef struct {
    logic [3:0] l;
    logic [3:0] r;
    logic [3:0] m;
    int         t;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  voice_valid;
  logic [15:0] voice_left;
  logic [15:0] voice_right;
  logic [3:0]  voice_ready;
  logic        clear_status;
  logic [3:0]  left_out;
  logic [3:0]  right_out;
  logic        sample_tick;
  logic        out_strobe;
  logic [3:0]  missed;

  exp_t       exp_q[$];
  logic [3:0] grant_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  dac_sample_scheduler #(
    .WIDTH(WIDTH),
    .SAMPLE_TIME(SAMPLE_TIME),
    .NUM_VOICES(NUM_VOICES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .voice_valid(voice_valid),
    .voice_left(voice_left),
    .voice_right(voice_right),
    .voice_ready(voice_ready),
    .clear_status(clear_status),
    .left_out(left_out),
    .right_out(right_out),
    .sample_tick(sample_tick),
    .out_strobe(out_strobe),
    .missed(missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [3:0] mixModel(input int sum);
`ifdef DAC_SCHED_AVERAGE_EN
    return 4'(sum >> 2);
`else
    return (sum > 15) ? 4'd15 : 4'(sum);
`endif
  endfunction

  // Counts negedges (including the current one) until sample_tick is seen.
  task automatic waitTick(output int n);
    n = 1;
    while (!sample_tick && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!sample_tick) checkOutput("tick_timeout", 0, 1);
  endtask

  task automatic pushPeriod(input int sum_l, input int sum_r, input logic [3:0] exp_m);
    exp_t e;
    e.l = mixModel(sum_l);
    e.r = mixModel(sum_r);
    e.m = exp_m;
    e.t = cyc;
    exp_q.push_back(e);
    grant_q.push_back(4'b0001);
    grant_q.push_back(4'b0010);
    grant_q.push_back(4'b0100);
    grant_q.push_back(4'b1000);
  endtask

  // Waits for the next tick, then loads the voices for the coming slots.
  task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] left,
                               input logic [15:0] right, input int sum_l,
                               input int sum_r, input logic [3:0] exp_m);
    int n;
    @(negedge clk);
    waitTick(n);
    voice_valid = valid;
    voice_left  = left;
    voice_right = right;
    pushPeriod(sum_l, sum_r, exp_m);
  endtask

  // Monitor: compares grants and committed outputs against the queues.
  always @(negedge clk) begin
    if (voice_ready != 4'b0000) begin
      if (grant_q.size() == 0) begin
        checkOutput("unexpected_grant", voice_ready, 0);
      end else begin
        checkOutput("voice_ready", voice_ready, grant_q.pop_front());
      end
    end
    if (out_strobe) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("left_out", left_out, e.l);
        checkOutput("right_out", right_out, e.r);
        checkOutput("missed_at_strobe", missed, e.m);
        checkOutput("strobe_latency", cyc - e.t, 6);
      end
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    clear_status = 1'b0;
    voice_valid  = 4'b1111;
    voice_left   = 16'h0000;
    voice_right  = 16'h0000;

    // 1: reset state and tick spacing
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_left_out", left_out, 0);
    checkOutput("rst_right_out", right_out, 0);
    checkOutput("rst_voice_ready", voice_ready, 0);
    checkOutput("rst_sample_tick", sample_tick, 0);
    checkOutput("rst_out_strobe", out_strobe, 0);
    checkOutput("rst_missed", missed, 0);
    reset = 1'b0;
    waitTick(n);
    checkOutput("first_tick_cycle", n, 16);
    pushPeriod(0, 0, 4'b0000);
    @(negedge clk);
    waitTick(n);
    checkOutput("tick_period", n, 16);
    pushPeriod(0, 0, 4'b0000);

    // 2: all valid, plain sum
    applyStimulus(4'b1111, 16'h4321, 16'h5000, 10, 5, 4'b0000);

    // 3: saturating (or averaging) mix
    applyStimulus(4'b1111, 16'h8888, 16'h0000, 32, 0, 4'b0000);

    // 4: voice 2 missing, then clear the sticky bit
    applyStimulus(4'b1011, 16'h1111, 16'h0000, 3, 0, 4'b0100);
    repeat (8) @(negedge clk);
    checkOutput("missed_before_clear", missed, 4'b0100);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    checkOutput("missed_after_clear", missed, 4'b0000);

    // 5: commit 10, then reset during slot 1 of the next period
    applyStimulus(4'b1111, 16'h4321, 16'h5000, 10, 5, 4'b0000);
    @(negedge clk);
    waitTick(n);
    grant_q.push_back(4'b0001);
    grant_q.push_back(4'b0010);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_voice_ready", voice_ready, 0);
    checkOutput("midreset_left_out", left_out, 0);
    checkOutput("midreset_right_out", right_out, 0);
    checkOutput("midreset_out_strobe", out_strobe, 0);
    applyStimulus(4'b1111, 16'h0123, 16'h2222, 6, 8, 4'b0000);

    // 6: clear_status collides with missed[0] being set
    applyStimulus(4'b1110, 16'h222F, 16'h0001, 6, 0, 4'b0001);
    @(negedge clk);
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    checkOutput("missed_set_beats_clear", missed, 4'b0001);

    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_strobes", exp_q.size(), 0);
    checkOutput("pending_grants", grant_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
